// File: rtl/seq_detect_pkg.sv
// Shared state encoding and default sizing for the serial pattern detection controller.
package seq_detect_pkg;

  localparam int unsigned DEF_MAX_LEN = 8;
  localparam int unsigned DEF_LEN_W   = 4;
  localparam int unsigned DEF_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/seq_window_match.sv
// Bit history window with fill tracking and a length-masked compare against the pattern.
module seq_window_match #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               shift_en,
  input  logic               clear,
  input  logic               overlap,
  input  logic               data_in,
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] pattern,
  output logic               hit
);

  localparam int unsigned HIST_W = MAX_LEN - 1;
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);

  logic [HIST_W-1:0]  history;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic               fill_ok;

  // Window is the stored history plus the bit offered this cycle.
  always_comb begin
    window = {history, data_in};
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      mask[i] = (32'(i) < 32'(len));
    end
    fill_ok = ((LEN_W+1)'(fill) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len);
    hit     = shift_en && fill_ok && (((window ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      history <= '0;
      fill    <= '0;
    end else if (clear) begin
      history <= '0;
      fill    <= '0;
    end else if (shift_en) begin
      if (!overlap && hit) begin
        history <= '0;
        fill    <= '0;
      end else begin
        history <= window[HIST_W-1:0];
        if (fill != FILL_MAX) fill <= fill + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector: config handshake, armed run, match counting and termination.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned LEN_W   = DEF_LEN_W,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  input  logic               data_valid,
  input  logic               data_in,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state, state_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [CNT_W-1:0]   tgt_q;
  logic               cfg_loaded;

  logic               cfg_hs, cfg_legal, shift_en, hit;
  logic               win_clear, done_d, err_d;
  logic [CNT_W-1:0]   count_next;

  assign cfg_hs     = cfg_valid && cfg_ready;
  assign cfg_legal  = (cfg_len != '0) && (32'(cfg_len) <= MAX_LEN);
  assign shift_en   = (state == RUN) && data_valid;
  assign count_next = (match_count == CNT_MAX) ? match_count : match_count + CNT_W'(1);
  assign match      = hit;

  seq_window_match #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_window (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .clear    (win_clear),
    .overlap  (ovl_q),
    .data_in  (data_in),
    .len      (len_q),
    .pattern  (pat_q),
    .hit      (hit)
  );

  // Next state, run arming and error/done pulse requests.
  always_comb begin
    state_d   = state;
    win_clear = 1'b0;
    done_d    = 1'b0;
    err_d     = cfg_hs && !cfg_legal;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (cfg_loaded && !cfg_hs) begin
            state_d   = RUN;
            win_clear = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort || (hit && (tgt_q != '0) && (count_next == tgt_q))) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      cfg_ready <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      busy      <= (state_d == RUN);
      cfg_ready <= (state_d != RUN);
      done      <= done_d;
      err       <= err_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q      <= '0;
      len_q      <= '0;
      ovl_q      <= 1'b0;
      tgt_q      <= '0;
      cfg_loaded <= 1'b0;
    end else if (cfg_hs && cfg_legal) begin
      pat_q      <= cfg_pattern;
      len_q      <= cfg_len;
      ovl_q      <= cfg_overlap;
      tgt_q      <= cfg_target;
      cfg_loaded <= 1'b1;
    end
  end

  // Count is cleared on arming and holds through DONE until the next run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_count <= '0;
    end else if (win_clear) begin
      match_count <= '0;
    end else if (hit) begin
      match_count <= count_next;
    end
  end

endmodule
